// File: rtl/clock_set_ctrl.sv
// Set-time controller for a 12-hour BCD clock: one-second strobe,
// two-button edit FSM and a one-cycle parallel load into the counter.
module clock_set_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int CNT_W         = 26,
    parameter int TIMEOUT_S     = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic       cur_pm,
    output logic       ena,
    output logic       load,
    output logic [7:0] ld_hh,
    output logic [7:0] ld_mm,
    output logic       ld_pm,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int TMO_W = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {RUN, SET_HH, SET_MM, COMMIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] presc_nxt;
    logic [TMO_W-1:0] tmo;
    logic             blink_r;
    logic [7:0]       sh_hh;
    logic [7:0]       sh_mm;
    logic             sh_pm;
    logic             wrap;
    logic             half;
    logic             editing;

    function automatic logic [7:0] inc_hh(input logic [7:0] hh);
        logic ok;
        ok = (hh[3:0] <= 4'd9) && (hh != 8'h00) && (hh <= 8'h12);
        if (!ok || hh == 8'h12)
            return 8'h01;
        else if (hh[3:0] == 4'd9)
            return 8'h10;
        else
            return hh + 8'd1;
    endfunction

    // Minutes wrap without carrying into hours
    function automatic logic [7:0] inc_mm(input logic [7:0] mm);
        logic ok;
        ok = (mm[3:0] <= 4'd9) && (mm <= 8'h59);
        if (!ok || mm == 8'h59)
            return 8'h00;
        else if (mm[3:0] == 4'd9)
            return {mm[7:4] + 4'd1, 4'h0};
        else
            return mm + 8'd1;
    endfunction

    assign wrap      = (presc == CNT_W'(TICKS_PER_SEC - 1));
    assign half      = (presc == CNT_W'(TICKS_PER_SEC / 2 - 1));
    assign presc_nxt = wrap ? '0 : presc + 1'b1;
    assign editing   = (state == SET_HH) || (state == SET_MM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            presc   <= '0;
            tmo     <= '0;
            blink_r <= 1'b0;
            sh_hh   <= 8'h12;
            sh_mm   <= 8'h00;
            sh_pm   <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (btn_mode) begin
                        sh_hh   <= cur_hh;
                        sh_mm   <= cur_mm;
                        sh_pm   <= cur_pm;
                        tmo     <= '0;
                        blink_r <= 1'b0;
                        presc   <= '0;
                        state   <= SET_HH;
                    end else begin
                        presc <= presc_nxt;
                    end
                end
                SET_HH, SET_MM: begin
                    presc <= presc_nxt;
                    if (wrap || half)
                        blink_r <= ~blink_r;
                    if (btn_mode) begin
                        tmo   <= '0;
                        state <= (state == SET_HH) ? SET_MM : COMMIT;
                    end else if (btn_inc) begin
                        tmo <= '0;
                        if (state == SET_HH) begin
                            sh_hh <= inc_hh(sh_hh);
                            if (sh_hh == 8'h11)
                                sh_pm <= ~sh_pm;
                        end else begin
                            sh_mm <= inc_mm(sh_mm);
                        end
                    end else if (wrap) begin
                        // Abandon the edit; the counter keeps its old time
                        if (tmo == TMO_W'(TIMEOUT_S - 1)) begin
                            tmo   <= '0;
                            presc <= '0;
                            state <= RUN;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    presc <= '0;
                    state <= RUN;
                end
            endcase
        end
    end

    assign ena   = (state == RUN) && wrap;
    assign load  = (state == COMMIT);
    assign blink = blink_r && editing;
    assign ld_hh = sh_hh;
    assign ld_mm = sh_mm;
    assign ld_pm = sh_pm;

    always_comb begin
        mode = 2'd0;
        if (state == SET_HH)
            mode = 2'd1;
        else if (state == SET_MM)
            mode = 2'd2;
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed vectors, timing corners and random
// button traffic compared against an arithmetic reference model.
module tb_clock_set_ctrl;

    localparam int T   = 4;
    localparam int TMO = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic       cur_pm;
    logic       ena;
    logic       load;
    logic [7:0] ld_hh;
    logic [7:0] ld_mm;
    logic       ld_pm;
    logic [1:0] mode;
    logic       blink;

    int checks = 0;
    int errors = 0;

    clock_set_ctrl #(
        .TICKS_PER_SEC(T),
        .CNT_W(3),
        .TIMEOUT_S(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .cur_hh(cur_hh),
        .cur_mm(cur_mm),
        .cur_pm(cur_pm),
        .ena(ena),
        .load(load),
        .ld_hh(ld_hh),
        .ld_mm(ld_mm),
        .ld_pm(ld_pm),
        .mode(mode),
        .blink(blink)
    );

    always #5 clk = ~clk;

    // Reference model: 0 run, 1 hours, 2 minutes, 3 commit
    int         m_state;
    int         m_ph;
    int         m_tmo;
    logic       m_blink;
    logic [7:0] m_hh;
    logic [7:0] m_mm;
    logic       m_pm;

    function automatic int b2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ph    = 0;
        m_tmo   = 0;
        m_blink = 1'b0;
        m_hh    = 8'h12;
        m_mm    = 8'h00;
        m_pm    = 1'b0;
    endtask

    task automatic model_step(input logic bm, input logic bi);
        int  h;
        int  m;
        bit  ok;
        bit  wr;
        wr = (m_ph == T - 1);
        if (m_state == 0) begin
            if (bm) begin
                m_hh = cur_hh; m_mm = cur_mm; m_pm = cur_pm;
                m_state = 1; m_ph = 0; m_tmo = 0; m_blink = 1'b0;
            end else begin
                m_ph = (m_ph + 1) % T;
            end
        end else if (m_state == 3) begin
            m_state = 0;
            m_ph = 0;
        end else begin
            if (wr || m_ph == T / 2 - 1)
                m_blink = ~m_blink;
            m_ph = (m_ph + 1) % T;
            if (bm) begin
                m_tmo = 0;
                m_state = m_state + 1;
            end else if (bi) begin
                m_tmo = 0;
                if (m_state == 1) begin
                    h  = b2i(m_hh);
                    ok = m_hh[3:0] <= 9 && h >= 1 && h <= 12;
                    if (ok && h == 11)
                        m_pm = ~m_pm;
                    m_hh = i2b(ok ? (h % 12) + 1 : 1);
                end else begin
                    m  = b2i(m_mm);
                    ok = m_mm[3:0] <= 9 && m_mm[7:4] <= 5;
                    m_mm = i2b(ok ? (m + 1) % 60 : 0);
                end
            end else if (wr) begin
                m_tmo = m_tmo + 1;
                if (m_tmo == TMO) begin
                    m_state = 0; m_ph = 0; m_tmo = 0;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [21:0] act;
        logic [21:0] exp;
        logic [1:0]  em;
        em  = (m_state == 1) ? 2'd1 : (m_state == 2) ? 2'd2 : 2'd0;
        act = {ena, load, mode, blink, ld_hh, ld_mm, ld_pm};
        exp = {(m_state == 0 && m_ph == T - 1), (m_state == 3), em,
               (m_blink && (m_state == 1 || m_state == 2)), m_hh, m_mm, m_pm};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model t=%0t got=%h expected=%h", $time, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input logic bm, input logic bi);
        btn_mode = bm;
        btn_inc  = bi;
        @(posedge clk);
        model_step(bm, bi);
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        compare_model();
    endtask

    typedef struct {
        logic       bm;
        logic       bi;
        logic [7:0] hh;
        logic [7:0] mm;
        logic       pm;
        logic [1:0] emode;
        logic       eload;
        logic [7:0] ehh;
        logic [7:0] emm;
        logic       epm;
    } vec_t;

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{1, 0, 8'h11, 8'h58, 0, 2'd1, 0, 8'h11, 8'h58, 0};
        vecs[1]  = '{0, 1, 8'h11, 8'h58, 0, 2'd1, 0, 8'h12, 8'h58, 1};
        vecs[2]  = '{1, 0, 8'h11, 8'h58, 0, 2'd2, 0, 8'h12, 8'h58, 1};
        vecs[3]  = '{0, 1, 8'h11, 8'h58, 0, 2'd2, 0, 8'h12, 8'h59, 1};
        vecs[4]  = '{0, 1, 8'h11, 8'h58, 0, 2'd2, 0, 8'h12, 8'h00, 1};
        vecs[5]  = '{1, 0, 8'h11, 8'h58, 0, 2'd0, 1, 8'h12, 8'h00, 1};
        vecs[6]  = '{0, 0, 8'h11, 8'h58, 0, 2'd0, 0, 8'h12, 8'h00, 1};
        vecs[7]  = '{1, 0, 8'h12, 8'h59, 1, 2'd1, 0, 8'h12, 8'h59, 1};
        vecs[8]  = '{0, 1, 8'h12, 8'h59, 1, 2'd1, 0, 8'h01, 8'h59, 1};
        vecs[9]  = '{1, 0, 8'h12, 8'h59, 1, 2'd2, 0, 8'h01, 8'h59, 1};
        vecs[10] = '{0, 1, 8'h12, 8'h59, 1, 2'd2, 0, 8'h01, 8'h00, 1};
        vecs[11] = '{1, 0, 8'h12, 8'h59, 1, 2'd0, 1, 8'h01, 8'h00, 1};
        vecs[12] = '{0, 0, 8'h12, 8'h59, 1, 2'd0, 0, 8'h01, 8'h00, 1};
        vecs[13] = '{1, 0, 8'h1A, 8'h30, 0, 2'd1, 0, 8'h1A, 8'h30, 0};
        vecs[14] = '{0, 1, 8'h1A, 8'h30, 0, 2'd1, 0, 8'h01, 8'h30, 0};
        vecs[15] = '{0, 1, 8'h1A, 8'h30, 0, 2'd1, 0, 8'h02, 8'h30, 0};
        vecs[16] = '{1, 0, 8'h1A, 8'h30, 0, 2'd2, 0, 8'h02, 8'h30, 0};
        vecs[17] = '{1, 0, 8'h1A, 8'h30, 0, 2'd0, 1, 8'h02, 8'h30, 0};
        vecs[18] = '{0, 0, 8'h1A, 8'h30, 0, 2'd0, 0, 8'h02, 8'h30, 0};

        reset = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        cur_hh = 8'h00;
        cur_mm = 8'h00;
        cur_pm = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare_model();

        // Idle after reset: ena in cycles 4, 8, 12 only
        chk("t1_ena0", 32'(ena), 32'(0));
        for (int i = 1; i < 12; i++) begin
            tick(0, 0);
            chk($sformatf("t1_ena%0d", i), 32'(ena), 32'(i % 4 == 3));
            chk($sformatf("t1_load%0d", i), 32'(load), 32'(0));
        end
        chk("t1_shadow", {23'd0, mode, ld_hh, ld_pm}, {23'd0, 2'd0, 8'h12, 1'b0});
        chk("t1_mm", 32'(ld_mm), 32'(8'h00));

        for (int i = 0; i < 19; i++) begin
            cur_hh = vecs[i].hh;
            cur_mm = vecs[i].mm;
            cur_pm = vecs[i].pm;
            tick(vecs[i].bm, vecs[i].bi);
            chk($sformatf("vec%0d", i), {13'd0, mode, load, ld_hh, ld_mm, ld_pm},
                {13'd0, vecs[i].emode, vecs[i].eload, vecs[i].ehh, vecs[i].emm, vecs[i].epm});
        end

        // Both buttons together: mode wins, increment dropped
        cur_hh = 8'h07; cur_mm = 8'h15; cur_pm = 1'b0;
        tick(1, 0);
        tick(0, 1);
        tick(1, 1);
        chk("t4_mode", 32'(mode), 32'(2));
        chk("t4_hh", 32'(ld_hh), 32'(8'h08));
        for (int i = 0; i < 4; i++) begin
            tick(0, 0);
            chk($sformatf("t4_ena%0d", i), 32'(ena), 32'(0));
        end
        tick(1, 0);
        tick(0, 0);

        // Timeout after two idle seconds in SET_HH
        tick(1, 0);
        for (int i = 1; i <= 8; i++) begin
            tick(0, 0);
            chk($sformatf("t5_mode%0d", i), 32'(mode), 32'(i < 8 ? 1 : 0));
            chk($sformatf("t5_load%0d", i), 32'(load), 32'(0));
        end
        for (int i = 1; i <= 3; i++) begin
            tick(0, 0);
            chk($sformatf("t5_ena%0d", i), 32'(ena), 32'(i == 3));
        end

        // Asynchronous reset mid-edit
        cur_hh = 8'h03; cur_mm = 8'h45; cur_pm = 1'b1;
        tick(1, 0);
        tick(0, 1);
        tick(1, 0);
        chk("t6_pre", 32'(mode), 32'(2));
        #1 reset = 1'b1;
        #1;
        chk("t6_mode", 32'(mode), 32'(0));
        chk("t6_blink", 32'(blink), 32'(0));
        chk("t6_ld", {15'd0, ld_hh, ld_mm, ld_pm}, {15'd0, 8'h12, 8'h00, 1'b0});
        chk("t6_load", 32'(load), 32'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_model();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    cur_hh = 8'($urandom);
                    cur_mm = 8'($urandom);
                end else begin
                    cur_hh = i2b(int'($urandom_range(1, 12)));
                    cur_mm = i2b(int'($urandom_range(0, 59)));
                end
                cur_pm = 1'($urandom);
            end
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
